axi_lite_req_arbiter: RTL and testbench

- Round-robin arbiter that shares one AXI4-Lite master port between NUM_REQ simple register-access requesters (e.g. firmware-status readers, build-version pollers).
- Each requester issues a single read or write (valid/write/addr/wdata) and gets a one-cycle ACK with read data and response.
- Sits in front of AXI4-Lite register slaves such as the build-revision register block; one transaction outstanding at a time.

---
 rtl/axi_lite_req_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_axi_lite_req_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port among NUM_REQ register requesters.
// Latency: request sample to AxVALID is 1 cycle; the ACK comes 1 cycle after the B/R handshake.
// Backpressure: only one transaction is outstanding; requesters hold REQ_VALID until their ACK.
//
// Ports:
//   AXI_ACLK, AXI_ARESET              clock, async active-high reset
//   REQ_VALID/WRITE/ADDR/WDATA        packed per-requester request fields (slice i = requester i)
//   REQ_ACK/RDATA/RESP                one-cycle completion pulse plus held read data and response
//   M_AXI_*                           AXI4-Lite master (AW, W, B, AR, R channels)
module axi_lite_req_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int M_AXI_ADDR_WIDTH = 32,
  parameter int M_AXI_DATA_WIDTH = 32
) (
  input  logic                                  AXI_ACLK,
  input  logic                                  AXI_ARESET,
  input  logic [NUM_REQ-1:0]                    REQ_VALID,
  input  logic [NUM_REQ-1:0]                    REQ_WRITE,
  input  logic [NUM_REQ*M_AXI_ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [NUM_REQ*M_AXI_DATA_WIDTH-1:0]   REQ_WDATA,
  output logic [NUM_REQ-1:0]                    REQ_ACK,
  output logic [M_AXI_DATA_WIDTH-1:0]           REQ_RDATA,
  output logic [1:0]                            REQ_RESP,
  output logic [M_AXI_ADDR_WIDTH-1:0]           M_AXI_AWADDR,
  output logic                                  M_AXI_AWVALID,
  input  logic                                  M_AXI_AWREADY,
  output logic [M_AXI_DATA_WIDTH-1:0]           M_AXI_WDATA,
  output logic [M_AXI_DATA_WIDTH/8-1:0]         M_AXI_WSTRB,
  output logic                                  M_AXI_WVALID,
  input  logic                                  M_AXI_WREADY,
  input  logic [1:0]                            M_AXI_BRESP,
  input  logic                                  M_AXI_BVALID,
  output logic                                  M_AXI_BREADY,
  output logic [M_AXI_ADDR_WIDTH-1:0]           M_AXI_ARADDR,
  output logic                                  M_AXI_ARVALID,
  input  logic                                  M_AXI_ARREADY,
  input  logic [M_AXI_DATA_WIDTH-1:0]           M_AXI_RDATA,
  input  logic [1:0]                            M_AXI_RRESP,
  input  logic                                  M_AXI_RVALID,
  output logic                                  M_AXI_RREADY
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_RESP, DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [GW-1:0]               grant_q, grant_d;
  logic [GW-1:0]               last_q, last_d;
  logic [M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                        awvalid_q, awvalid_d;
  logic                        wvalid_q, wvalid_d;
  logic                        bready_q, bready_d;
  logic                        arvalid_q, arvalid_d;
  logic                        rready_q, rready_d;
  logic [NUM_REQ-1:0]          ack_q, ack_d;
  logic [M_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                  resp_q, resp_d;

  logic                        any_req;
  logic [GW-1:0]               pick;
  logic [GW-1:0]               cand;

  // Search last+1 .. last+NUM_REQ; walking downward lets the nearest
  // candidate after the previous winner overwrite the farther ones.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = GW'((int'(last_q) + k) % NUM_REQ);
      if (REQ_VALID[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    ack_d     = '0;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          last_d  = pick;
          addr_d  = REQ_ADDR[pick*M_AXI_ADDR_WIDTH +: M_AXI_ADDR_WIDTH];
          wdata_d = REQ_WDATA[pick*M_AXI_DATA_WIDTH +: M_AXI_DATA_WIDTH];
          if (REQ_WRITE[pick]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR_ADDR_DATA: begin
        // AW and W complete independently; leave once neither is pending.
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          resp_d         = M_AXI_BRESP;
          rdata_d        = '0;
          bready_d       = 1'b0;
          ack_d[grant_q] = 1'b1;
          state_d        = DONE;
        end
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (M_AXI_RVALID) begin
          rdata_d        = M_AXI_RDATA;
          resp_d         = M_AXI_RRESP;
          rready_d       = 1'b0;
          ack_d[grant_q] = 1'b1;
          state_d        = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= GW'(NUM_REQ - 1);
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  assign REQ_ACK       = ack_q;
  assign REQ_RDATA     = rdata_q;
  assign REQ_RESP      = resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
module tb_axi_lite_req_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_write = '0;
  logic [127:0] req_addr  = '0;
  logic [127:0] req_wdata = '0;
  logic [3:0]   req_ack;
  logic [31:0]  req_rdata;
  logic [1:0]   req_resp;
  logic [31:0]  awaddr, wdata, araddr, rdata = '0;
  logic [3:0]   wstrb;
  logic         awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [1:0]   bresp = '0, rresp = '0;
  logic         bvalid = 1'b0, bready, arvalid, arready = 1'b0;
  logic         rvalid = 1'b0, rready;

  int checks = 0;
  int errors = 0;
  int aw_hs  = 0;
  int w_hs   = 0;

  axi_lite_req_arbiter #(.NUM_REQ(4), .M_AXI_ADDR_WIDTH(32), .M_AXI_DATA_WIDTH(32)) dut (
    .AXI_ACLK(clk), .AXI_ARESET(rst),
    .REQ_VALID(req_valid), .REQ_WRITE(req_write), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .REQ_ACK(req_ack), .REQ_RDATA(req_rdata), .REQ_RESP(req_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count handshakes seen at the coming edge, then step.
  task automatic cyc();
    if (awvalid && awready) aw_hs++;
    if (wvalid && wready)   w_hs++;
    tick();
  endtask

  task automatic idle_slave();
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; rvalid = 1'b0; bresp = '0; rresp = '0; rdata = '0;
  endtask

  // Zero-wait slave: always ready, answers B/R as soon as the arbiter is ready for them.
  task automatic slave_cycle();
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    bvalid = bready; bresp = 2'd0;
    rvalid = rready; rresp = 2'd0; rdata = 32'hA000_0000 | araddr;
    tick();
  endtask

  task automatic wait_ack(output logic [3:0] a);
    a = '0;
    for (int c = 0; c < 50; c++) begin
      slave_cycle();
      if (req_ack != 4'b0) begin
        a = req_ack;
        break;
      end
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_write[i] = w;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    req_valid = '0;
    idle_slave();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    req_valid = '0;
    idle_slave();
    rst = 1'b1;
    #3;
    checks++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin errors++; $display("FAIL reset_valid_ready: got %b expected 00000", {awvalid, wvalid, arvalid, bready, rready}); end
    checks++; if (req_ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0000", req_ack); end
    checks++; if ({req_rdata, req_resp} !== 34'b0) begin errors++; $display("FAIL reset_rdata_resp: got %h/%h expected 0/0", req_rdata, req_resp); end
    checks++; if ({awaddr, araddr, wdata} !== 96'b0) begin errors++; $display("FAIL reset_addr_data: got %h %h %h expected 0", awaddr, araddr, wdata); end
    checks++; if (wstrb !== 4'hF) begin errors++; $display("FAIL wstrb: got %h expected f", wstrb); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    int ar_cnt;
    logic ack_early;
    ar_cnt = 0;
    ack_early = 1'b0;
    set_req(1, 1'b0, 32'h8, 32'h0);
    req_valid = 4'b0010;
    tick();
    checks++; if ({arvalid, araddr} !== {1'b1, 32'h8}) begin errors++; $display("FAIL read_ar_latency: got %b/%h expected 1/00000008", arvalid, araddr); end
    for (int i = 0; i < 3; i++) begin
      if (arvalid) ar_cnt++;
      if (req_ack !== 4'b0) ack_early = 1'b1;
      tick();
    end
    arready = 1'b1;
    if (arvalid) ar_cnt++;
    tick();
    arready = 1'b0;
    checks++; if (ar_cnt !== 4) begin errors++; $display("FAIL read_arvalid_hold: got %0d cycles expected 4", ar_cnt); end
    checks++; if ({arvalid, rready} !== 2'b01) begin errors++; $display("FAIL read_rready: got arvalid/rready %b expected 01", {arvalid, rready}); end
    rvalid = 1'b1; rdata = 32'h0000_03E9; rresp = 2'd0;
    if (req_ack !== 4'b0) ack_early = 1'b1;
    tick();
    rvalid = 1'b0; rdata = '0;
    req_valid = 4'b0000;
    checks++; if (ack_early !== 1'b0) begin errors++; $display("FAIL read_ack_early: got %b expected 0", ack_early); end
    checks++; if (req_ack !== 4'b0010) begin errors++; $display("FAIL read_ack: got %b expected 0010", req_ack); end
    checks++; if ({req_rdata, req_resp} !== {32'h0000_03E9, 2'd0}) begin errors++; $display("FAIL read_data: got %h/%0d expected 000003e9/0", req_rdata, req_resp); end
    tick();
    checks++; if (req_ack !== 4'b0) begin errors++; $display("FAIL read_ack_width: got %b expected 0000", req_ack); end
    checks++; if (req_rdata !== 32'h0000_03E9) begin errors++; $display("FAIL read_data_hold: got %h expected 000003e9", req_rdata); end
  endtask

  task automatic test_write_order();
    aw_hs = 0;
    w_hs  = 0;
    set_req(0, 1'b1, 32'h4, 32'hDEAD_BEEF);
    req_valid = 4'b0001;
    tick();
    checks++; if ({awvalid, wvalid, awaddr, wdata} !== {2'b11, 32'h4, 32'hDEAD_BEEF}) begin errors++; $display("FAIL write_issue: got %b%b %h %h expected 11 00000004 deadbeef", awvalid, wvalid, awaddr, wdata); end
    // Requester changes its fields after grant; the captured ones must stay.
    set_req(0, 1'b1, 32'h40, 32'h1111_1111);
    wready = 1'b1;
    cyc();
    wready = 1'b0;
    checks++; if ({awvalid, wvalid} !== 2'b10) begin errors++; $display("FAIL write_w_first: got aw/w %b expected 10", {awvalid, wvalid}); end
    cyc();
    checks++; if ({awvalid, awaddr} !== {1'b1, 32'h4}) begin errors++; $display("FAIL write_aw_held: got %b/%h expected 1/00000004", awvalid, awaddr); end
    awready = 1'b1;
    cyc();
    awready = 1'b0;
    checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin errors++; $display("FAIL write_to_resp: got aw/w/b %b expected 001", {awvalid, wvalid, bready}); end
    awready = 1'b1; wready = 1'b1;
    cyc();
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bresp = 2'd2;
    cyc();
    bvalid = 1'b0; bresp = 2'd0;
    req_valid = 4'b0000;
    checks++; if ({req_ack, req_resp, req_rdata} !== {4'b0001, 2'd2, 32'h0}) begin errors++; $display("FAIL write_ack: got %b/%0d/%h expected 0001/2/00000000", req_ack, req_resp, req_rdata); end
    checks++; if (bready !== 1'b0) begin errors++; $display("FAIL write_bready_drop: got %b expected 0", bready); end
    cyc();
    checks++; if ({aw_hs, w_hs} !== {32'd1, 32'd1}) begin errors++; $display("FAIL write_hs_count: got aw=%0d w=%0d expected 1/1", aw_hs, w_hs); end
    checks++; if ({req_ack, req_resp} !== {4'b0, 2'd2}) begin errors++; $display("FAIL write_resp_hold: got %b/%0d expected 0000/2", req_ack, req_resp); end
  endtask

  task automatic test_fairness();
    logic [3:0] got [6];
    logic [3:0] exp_g [6];
    int n;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001; exp_g[5] = 4'b0010;
    n = 0;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, (i % 2) == 1, 32'h100 + 32'(i * 4), 32'h5000 + 32'(i));
    req_valid = 4'b1111;
    for (int c = 0; c < 200 && n < 6; c++) begin
      slave_cycle();
      if (req_ack != 4'b0) begin
        got[n] = req_ack;
        n++;
      end
    end
    req_valid = '0;
    idle_slave();
    tick();
    checks++; if (n !== 6) begin errors++; $display("FAIL fair_count: got %0d grants expected 6", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (got[i] !== exp_g[i]) begin errors++; $display("FAIL fair_order[%0d]: got %b expected %b", i, got[i], exp_g[i]); end
    end
  endtask

  task automatic test_rr_pointer();
    logic [3:0] a;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h20 + 32'(i * 4), 32'h0);
    req_valid = 4'b0100;
    wait_ack(a);
    checks++; if (a !== 4'b0100) begin errors++; $display("FAIL rr_req2: got %b expected 0100", a); end
    req_valid = 4'b1001;
    wait_ack(a);
    checks++; if (a !== 4'b1000) begin errors++; $display("FAIL rr_req3_first: got %b expected 1000", a); end
    req_valid = 4'b0001;
    wait_ack(a);
    checks++; if (a !== 4'b0001) begin errors++; $display("FAIL rr_req0_next: got %b expected 0001", a); end
    req_valid = '0;
    idle_slave();
    tick();
  endtask

  task automatic test_backpressure();
    logic bad;
    bad = 1'b0;
    set_req(1, 1'b0, 32'h30, 32'h0);
    req_valid = 4'b0010;
    tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (req_ack !== 4'b0 || rready !== 1'b1) bad = 1'b1;
      tick();
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL bp_wait: got early ack or rready low (ack=%b rready=%b) expected none", req_ack, rready); end
    rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'd0;
    tick();
    rvalid = 1'b0; rdata = '0;
    req_valid = '0;
    checks++; if ({req_ack, req_rdata} !== {4'b0010, 32'h1234_5678}) begin errors++; $display("FAIL bp_ack: got %b/%h expected 0010/12345678", req_ack, req_rdata); end
    tick();
    checks++; if (req_ack !== 4'b0) begin errors++; $display("FAIL bp_ack_width: got %b expected 0000", req_ack); end
  endtask

  task automatic test_reset_midop();
    logic [3:0] a;
    int c;
    set_req(2, 1'b1, 32'h44, 32'hCAFE_0002);
    set_req(0, 1'b0, 32'h50, 32'h0);
    set_req(3, 1'b0, 32'h5C, 32'h0);
    req_valid = 4'b0100;
    awready = 1'b1; wready = 1'b1;
    c = 0;
    while (bready !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    checks++; if (bready !== 1'b1) begin errors++; $display("FAIL midop_reach_wr_resp: got bready %b expected 1", bready); end
    #2;
    rst = 1'b1;
    req_valid = '0;
    idle_slave();
    #1;
    checks++; if ({bready, awvalid, wvalid, req_ack} !== 7'b0) begin errors++; $display("FAIL midop_async_clear: got b/aw/w %b ack %b expected 000 0000", {bready, awvalid, wvalid}, req_ack); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 4'b1001;
    req_write = 4'b0000;
    wait_ack(a);
    checks++; if (a !== 4'b0001) begin errors++; $display("FAIL midop_first_grant: got %b expected 0001", a); end
    checks++; if (req_rdata !== (32'hA000_0000 | 32'h50)) begin errors++; $display("FAIL midop_rdata: got %h expected a0000050", req_rdata); end
    req_valid = '0;
    idle_slave();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_order();
    test_fairness();
    test_rr_pointer();
    test_backpressure();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
